// File: rtl/ro_sense_pkg.sv
// Shared constants and FSM state encoding for the ring-oscillator frequency counter.
package ro_sense_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int WIN_BASE   = 1024;
    localparam int GATE_SEL_W = 3;
    localparam int WIN_CNT_W  = 18;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FLUSH = 2'd1;
    localparam state_t ST_GATE  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Last window-counter value for a given gate select: (1024 << sel) - 1.
    function automatic logic [WIN_CNT_W-1:0] win_last(input logic [GATE_SEL_W-1:0] sel);
        return (WIN_CNT_W'(WIN_BASE) << sel) - WIN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Multi-flop synchronizer for the asynchronous ring-oscillator input plus a
// one-flop rising-edge detector on the synchronized signal.
module ro_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ro_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ro_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/ro_freq_counter.sv
// Gated rising-edge counter for a divided ring-oscillator output.
// Define RO_CNT_OVF_EN for a saturating accumulator and an ovf output.
module ro_freq_counter
    import ro_sense_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  ro_in,
    input  logic [GATE_SEL_W-1:0] gate_sel,
    output logic [CNT_W-1:0]      count,
    output logic                  count_valid,
`ifdef RO_CNT_OVF_EN
    output logic                  ovf,
`endif
    output logic                  busy
);

    localparam logic [WIN_CNT_W-1:0] FLUSH_LAST = WIN_CNT_W'(SYNC_STAGES);

    state_t                  state;
    logic [WIN_CNT_W-1:0]    win_cnt;
    logic [GATE_SEL_W-1:0]   sel_q;
    logic [CNT_W-1:0]        acc;
    logic [CNT_W-1:0]        acc_next;
    logic                    rise;

    ro_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .reset (reset),
        .ro_in (ro_in),
        .rise  (rise)
    );

`ifdef RO_CNT_OVF_EN
    logic sat;

    assign acc_next = (rise && (acc != '1)) ? acc + CNT_W'(1) : acc;

    // sat remembers that an edge was dropped at full scale during this window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat <= 1'b0;
            ovf <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (!en) begin
                sat <= 1'b0;
            end else if (state == ST_GATE) begin
                if (rise && (acc == '1)) begin
                    sat <= 1'b1;
                end
            end else if (state == ST_DONE) begin
                ovf <= sat;
                sat <= 1'b0;
            end else begin
                sat <= 1'b0;
            end
        end
    end
`else
    assign acc_next = acc + CNT_W'(rise);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            win_cnt     <= '0;
            sel_q       <= '0;
            acc         <= '0;
            count       <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (!en) begin
                state   <= ST_IDLE;
                win_cnt <= '0;
                acc     <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_FLUSH;
                        win_cnt <= '0;
                    end
                    ST_FLUSH: begin
                        if (win_cnt == FLUSH_LAST) begin
                            state   <= ST_GATE;
                            win_cnt <= '0;
                            sel_q   <= gate_sel;
                            acc     <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_CNT_W'(1);
                        end
                    end
                    ST_GATE: begin
                        acc <= acc_next;
                        if (win_cnt == win_last(sel_q)) begin
                            state   <= ST_DONE;
                            win_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        // The edge seen during DONE opens the next window so none is lost.
                        count       <= acc;
                        count_valid <= 1'b1;
                        acc         <= CNT_W'(rise);
                        sel_q       <= gate_sel;
                        state       <= ST_GATE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed/randomized bench for ro_freq_counter: a 16-bit/2-stage and an
// 8-bit/3-stage instance share stimulus and are checked against a history-based edge model.
module tb_ro_freq_counter;

    localparam int S_A = 2;
    localparam int S_B = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        ro_in = 1'b0;
    logic [2:0]  gate_sel;
    logic [15:0] count_a;
    logic        valid_a;
    logic        busy_a;
    logic [7:0]  count_b;
    logic        valid_b;
    logic        busy_b;
`ifdef RO_CNT_OVF_EN
    logic        ovf_a;
    logic        ovf_b;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mode     = 0;
    int ph       = 0;
    logic hist [0:65535];

    ro_freq_counter #(.SYNC_STAGES(S_A), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .en(en), .ro_in(ro_in), .gate_sel(gate_sel),
        .count(count_a), .count_valid(valid_a),
`ifdef RO_CNT_OVF_EN
        .ovf(ovf_a),
`endif
        .busy(busy_a)
    );

    ro_freq_counter #(.SYNC_STAGES(S_B), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .en(en), .ro_in(ro_in), .gate_sel(gate_sel),
        .count(count_b), .count_valid(valid_b),
`ifdef RO_CNT_OVF_EN
        .ovf(ovf_b),
`endif
        .busy(busy_b)
    );

    always #5 clk = ~clk;

    // hist[k] is the ro_in value sampled at rising edge number k.
    always @(posedge clk) begin
        if (cyc < 65536) hist[cyc] <= ro_in;
        cyc <= cyc + 1;
    end

    // mode: 0 low, 1 high, 2 period-4 square, 3 period-2 square, 4 random
    always @(posedge clk) begin
        #1;
        ph = ph + 1;
        case (mode)
            0:       ro_in = 1'b0;
            1:       ro_in = 1'b1;
            2:       ro_in = ((ph >> 1) & 1) != 0;
            3:       ro_in = (ph & 1) != 0;
            default: ro_in = $urandom_range(0, 1) != 0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rising edges of ro_in between samples e+lo and e+hi, where e is the edge en was sampled on.
    function automatic int rises(input int e, input int lo, input int hi);
        int n = 0;
        for (int m = lo; m <= hi; m++) begin
            if (hist[e + m] && !hist[e + m - 1]) n++;
        end
        return n;
    endfunction

    function automatic int exp_b(input int raw);
`ifdef RO_CNT_OVF_EN
        return (raw > 255) ? 255 : raw;
`else
        return raw % 256;
`endif
    endfunction

    // Runs until both instances should have pulsed for the window covering samples [lo,hi].
    task automatic run_window(input int e, input int lo, input int hi, input string tag, output int raw);
        int pa = e + S_A + hi + 1;
        int pb = e + S_B + hi + 1;
        int fa = -1;
        int fb = -1;
        int na = 0;
        int nb = 0;
        logic oa = 1'b0;
        logic ob = 1'b0;
        while (cyc - 1 < pb) begin
            tick();
            if (valid_a) begin
                na++;
                if (fa < 0) fa = cyc - 1;
`ifdef RO_CNT_OVF_EN
                oa = ovf_a;
`endif
            end
            if (valid_b) begin
                nb++;
                if (fb < 0) fb = cyc - 1;
`ifdef RO_CNT_OVF_EN
                ob = ovf_b;
`endif
            end
        end
        raw = rises(e, lo, hi);
        check({tag, "_edge_a"},  fa, pa);
        check({tag, "_npulse_a"}, na, 1);
        check({tag, "_count_a"}, {16'd0, count_a}, raw % 65536);
        check({tag, "_edge_b"},  fb, pb);
        check({tag, "_npulse_b"}, nb, 1);
        check({tag, "_count_b"}, {24'd0, count_b}, exp_b(raw));
`ifdef RO_CNT_OVF_EN
        check({tag, "_ovf_a"}, {31'd0, oa}, 0);
        check({tag, "_ovf_b"}, {31'd0, ob}, (raw > 255) ? 1 : 0);
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_count_a"}, {16'd0, count_a}, 0);
        check({tag, "_valid_a"}, {31'd0, valid_a}, 0);
        check({tag, "_busy_a"},  {31'd0, busy_a}, 0);
        check({tag, "_count_b"}, {24'd0, count_b}, 0);
        check({tag, "_valid_b"}, {31'd0, valid_b}, 0);
        check({tag, "_busy_b"},  {31'd0, busy_b}, 0);
`ifdef RO_CNT_OVF_EN
        check({tag, "_ovf_a"}, {31'd0, ovf_a}, 0);
        check({tag, "_ovf_b"}, {31'd0, ovf_b}, 0);
`endif
    endtask

    initial begin
        int e;
        int hi;
        int raw;
        int w;
        int npulse;
        logic [15:0] held_a;
        logic [7:0]  held_b;

        reset = 1'b1;
        en = 1'b0;
        gate_sel = 3'd0;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;

        // Period-4 input, back-to-back windows, mid-window gate_sel changes.
        mode = 2;
        repeat (8) tick();
        e = cyc;
        en = 1'b1;
        run_window(e, 2, 1025, "win1", raw);
        check("win1_is_256", {16'd0, count_a}, 256);
        hi = 1025;
        run_window(e, hi + 1, hi + 1025, "win2", raw);
        hi += 1025;
        repeat (300) tick();
        gate_sel = 3'd3;
        run_window(e, hi + 1, hi + 1025, "win3_sel_ignored", raw);
        hi += 1025;
        repeat (300) tick();
        gate_sel = 3'd0;
        run_window(e, hi + 1, hi + 8193, "win4_w8192", raw);
        hi += 8193;

        // Drop en 500 cycles into the next window.
        held_a = count_a;
        held_b = count_b;
        repeat (499) tick();
        check("en_drop_busy_before", {31'd0, busy_a}, 1);
        en = 1'b0;
        tick();
        check("en_drop_busy_a", {31'd0, busy_a}, 0);
        check("en_drop_busy_b", {31'd0, busy_b}, 0);
        npulse = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (valid_a || valid_b) npulse++;
        end
        check("en_drop_no_pulse", npulse, 0);
        check("en_drop_hold_a", {16'd0, count_a}, {16'd0, held_a});
        check("en_drop_hold_b", {24'd0, count_b}, {24'd0, held_b});

        // Random input with a random gate window, two windows.
        mode = 4;
        gate_sel = 3'($urandom_range(0, 2));
        w = 1024 << gate_sel;
        repeat (5) tick();
        e = cyc;
        en = 1'b1;
        run_window(e, 2, w + 1, "rand1", raw);
        run_window(e, w + 2, 2 * w + 2, "rand2", raw);
        en = 1'b0;
        tick();

        // Period-2 input saturates/wraps the 8-bit instance.
        mode = 3;
        gate_sel = 3'd0;
        repeat (6) tick();
        e = cyc;
        en = 1'b1;
        run_window(e, 2, 1025, "period2", raw);
        check("period2_is_512", {16'd0, count_a}, 512);
        en = 1'b0;
        tick();

        // Constant low, then constant high.
        mode = 0;
        repeat (8) tick();
        e = cyc;
        en = 1'b1;
        run_window(e, 2, 1025, "const0", raw);
        check("const0_zero", {16'd0, count_a}, 0);
        en = 1'b0;
        mode = 1;
        repeat (8) tick();
        e = cyc;
        en = 1'b1;
        run_window(e, 2, 1025, "const1", raw);
        check("const1_zero", {16'd0, count_a}, 0);
        en = 1'b0;
        tick();

        // Reset in the middle of a gate window discards it.
        mode = 2;
        repeat (4) tick();
        en = 1'b1;
        npulse = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (valid_a || valid_b) npulse++;
        end
        check("midreset_no_pulse", npulse, 0);
        check("midreset_busy_before", {31'd0, busy_a}, 1);
        reset = 1'b1;
        tick();
        check_idle_outputs("midreset");
        reset = 1'b0;
        e = cyc;
        run_window(e, 2, 1025, "post_reset", raw);
        en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ro_freq_counter.md
RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop count on ro_in (legal 2..4).
REQ-002 SHALL have parameter CNT_W, default 16, width of edge accumulator and count output.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  measurement enable; low forces idle.
REQ-006 SHALL have port ro_in  input  1  asynchronous ring-oscillator output (divided), frequency < clk/2.
REQ-007 SHALL have port gate_sel  input  3  gate window select.
REQ-008 SHALL have port count  output  CNT_W  rising-edge count of the last completed window.
REQ-009 SHALL have port count_valid  output  1  one-cycle pulse when count updates.
REQ-010 SHALL have port busy  output  1  high in FLUSH, GATE or DONE.

Function
REQ-011 SHALL pass ro_in through SYNC_STAGES flops, then a 1-flop rising-edge detector (edge = sync & ~prev).
REQ-012 SHALL implement FSM states IDLE, FLUSH, GATE, DONE.
REQ-013 IDLE -> FLUSH when en=1; FLUSH lasts SYNC_STAGES+1 cycles, no counting, synchronizer primed.
REQ-014 FLUSH -> GATE; on entry gate_sel is latched, window length W = 1024 << gate_sel clocks (1024..131072); gate_sel changes mid-window SHALL be ignored.
REQ-015 In GATE, accumulator SHALL increment by 1 per detected edge; window counter (18 bits) counts W cycles, then -> DONE.
REQ-016 In DONE (one cycle): count <= accumulator, count_valid=1, accumulator <= edge (0 or 1) so no edge is lost; -> GATE (new latch of gate_sel) if en=1, else -> IDLE.
REQ-017 count SHALL hold its value between DONE cycles, including while idle.
REQ-018 en=0 in any state SHALL go to IDLE next cycle, clear accumulator and window counter, no count_valid; count keeps the last value.
REQ-019 Latency: first count_valid SHALL occur SYNC_STAGES+1+W+1 cycles after the cycle en is sampled high; back-to-back windows every W+1 cycles.

Reset
REQ-020 reset=1 SHALL force IDLE, count=0, count_valid=0, busy=0, accumulator=0, window counter=0, synchronizer/edge flops=0.
REQ-021 reset SHALL take priority over en; reset mid-window SHALL discard the partial window without pulsing count_valid.

Configuration
REQ-022 Macro RO_CNT_OVF_EN SHALL control overflow handling.
REQ-023 With RO_CNT_OVF_EN defined: accumulator saturates at 2^CNT_W-1; extra port ovf (output, 1) = 1 with count_valid when saturation occurred in that window, else 0; reset value 0.
REQ-024 Without RO_CNT_OVF_EN: accumulator wraps modulo 2^CNT_W; no ovf port.

Structure
REQ-025 Package ro_sense_pkg SHALL hold the FSM state enum, CNT_W default, window base constant (1024) and gate_sel width.
REQ-026 Sub-module ro_edge_sync (synchronizer + edge detector, parameter SYNC_STAGES) SHALL be instantiated once.

Verification
REQ-027 ro_in toggled synchronously every 2 clk (period 4), gate_sel=0, en=1 -> count=256, count_valid single pulse at cycle SYNC_STAGES+1+1024+1.
REQ-028 Same stimulus, en held -> consecutive windows each count=256, pulses 1025 cycles apart, no edge lost across DONE.
REQ-029 Period-2 ro_in, gate_sel=7 (W=131072 -> 65536 edges) -> with RO_CNT_OVF_EN count=0xFFFF, ovf=1; without, count=0x0000.
REQ-030 en dropped at cycle 500 of a window -> no count_valid, busy=0 next cycle, count keeps previous 256.
REQ-031 reset pulsed mid-GATE -> all outputs 0 next cycle; gate_sel changed 0->3 mid-window -> that window still 1024 cycles, next window 8192.
REQ-032 ro_in constant 1 or constant 0 through a full window -> count=0.
